// File: rtl/counter_arbiter_if.sv
//==============================================================================
// counter_arbiter_if : request/grant bus plus shared-counter control and readback
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface counter_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  cnt_reset;
  logic                  cnt_enable;
  logic [WIDTH-1:0]      cnt_value;

  // master is the requesting logic together with the shared counter
  modport master (
    output req, len, cnt_value,
    input  grant, done, busy, cnt_reset, cnt_enable
  );

  modport slave (
    input  req, len, cnt_value,
    output grant, done, busy, cnt_reset, cnt_enable
  );
endinterface

`default_nettype wire

// File: rtl/counter_arbiter.sv
//==============================================================================
// counter_arbiter : shares one up-counter among NREQ interval requesters.
// Optional macro COUNTER_ARB_RR_EN selects round-robin instead of fixed priority.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  wire logic        clock,
  input  wire logic        reset,
  counter_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [IW-1:0]   win_q, win_d;
  logic            found;
  logic [IW-1:0]   pick;
  logic            owner_req;
  logic [WIDTH-1:0] len_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_arr[gi] = bus.len[gi*WIDTH +: WIDTH];
  end

`ifdef COUNTER_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  // search starts at ptr and wraps from NREQ-1 back to 0
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!found && bus.req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end
`endif

  assign owner_req = bus.req[win_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    win_d   = win_q;
`ifdef COUNTER_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = CLEAR;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          len_d         = len_arr[pick];
          win_d         = pick;
`ifdef COUNTER_ARB_RR_EN
          ptr_d         = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
`endif
        end
      end
      CLEAR: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // a dropped request aborts even on the terminal count
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (bus.cnt_value == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      len_q   <= '0;
      win_q   <= '0;
`ifdef COUNTER_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      win_q   <= win_d;
`ifdef COUNTER_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = (state_q == DONE) ? grant_q : '0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.cnt_reset  = (state_q == CLEAR);
  assign bus.cnt_enable = (state_q == RUN) && (bus.cnt_value != len_q);

endmodule

`default_nettype wire

// File: tb/tb_counter_arbiter.sv
//==============================================================================
// tb_counter_arbiter : directed and random checks of counter_arbiter with a
// modelled 4-bit counter. Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  counter_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // shared counter: synchronous reset, enable-gated, #1 output delay
  logic [WIDTH-1:0] cnt = '0;
  always @(posedge clock) begin
    if (bus.cnt_reset)       cnt <= '0;
    else if (bus.cnt_enable) cnt <= cnt + 1'b1;
  end
  assign #1 bus.cnt_value = cnt;

  int n_vec = 0;
  int n_err = 0;

  // reference model: one operation described by owner, length and cycle offset
  bit m_active;
  int m_owner, m_len, m_t, m_ptr;
  int dut_order[$];
  logic [NREQ-1:0] prev_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg;
    eg = '0;
    if (m_active) eg[m_owner] = 1'b1;
    check("grant", 32'(bus.grant), 32'(eg));
    check("done", 32'(bus.done), (m_active && m_t == m_len + 3) ? 32'(eg) : 32'd0);
    check("busy", 32'(bus.busy), 32'(m_active));
    check("cnt_reset", 32'(bus.cnt_reset), 32'(m_active && m_t == 1));
    check("cnt_enable", 32'(bus.cnt_enable), 32'(m_active && m_t >= 2 && m_t <= m_len + 1));
    if (m_active && m_t >= 2 && m_t <= m_len + 2)
      check("cnt_value", 32'(bus.cnt_value), 32'(m_t - 2));
    if (bus.grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < NREQ; i++)
        if (bus.grant[i]) dut_order.push_back(i);
    end
    prev_grant = bus.grant;
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] r);
    int c;
    for (int k = 0; k < NREQ; k++) begin
`ifdef COUNTER_ARB_RR_EN
      c = (m_ptr + k) % NREQ;
`else
      c = k;
`endif
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_advance(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] l);
    int w;
    if (!m_active) begin
      if (r != '0) begin
        w        = model_pick(r);
        m_active = 1'b1;
        m_owner  = w;
        m_len    = int'(l[w*WIDTH +: WIDTH]);
        m_t      = 1;
        m_ptr    = (w + 1) % NREQ;
      end
    end else if (m_t <= m_len + 2 && !r[m_owner]) begin
      m_active = 1'b0;
    end else if (m_t == m_len + 3) begin
      m_active = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  // check the current cycle, then drive this cycle's inputs
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] l);
    check_outputs();
    bus.req = r;
    bus.len = l;
    model_advance(r, l);
    @(negedge clock);
  endtask

  task automatic hold_until_done(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] l);
    step(r, l);
    for (int k = 0; k < 40 && !(m_active && m_t == m_len + 3); k++)
      step(r, l);
    step('0, l);
  endtask

  initial begin
    logic [NREQ-1:0]       rq;
    logic [NREQ*WIDTH-1:0] ln;
    int                    exp_order[5];
    int                    n_order;
    bit                    own;

    bus.req    = '0;
    bus.len    = '0;
    m_active   = 1'b0;
    m_owner    = 0;
    m_len      = 0;
    m_t        = 0;
    m_ptr      = 0;
    prev_grant = '0;

    @(negedge clock);
    check_outputs();
    reset = 1'b1;

    // single request, len0 = 3
    hold_until_done(4'b0001, 16'h0003);
    step('0, '0);

    // zero length on requester 1
    hold_until_done(4'b0010, 16'h0000);
    step('0, '0);

    // contention: all four held, each len = 1
    dut_order.delete();
    repeat (26) step(4'b1111, 16'h1111);
    repeat (3) step('0, 16'h1111);
`ifdef COUNTER_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
    n_order   = 5;
`else
    exp_order = '{0, 0, 0, 0, 0};
    n_order   = 3;
`endif
    check("order_count", 32'(dut_order.size() >= n_order), 32'd1);
    for (int k = 0; k < n_order; k++)
      if (k < dut_order.size())
        check("order", 32'(dut_order[k]), 32'(exp_order[k]));

    // abort in RUN with cnt_value = 2, len0 = 9
    step(4'b0001, 16'h0009);
    for (int k = 0; k < 20 && !(m_active && m_t == 4); k++)
      step(4'b0001, 16'h0009);
    check("abort_cnt", 32'(bus.cnt_value), 32'd2);
    step('0, 16'h0009);
    repeat (2) step('0, 16'h0009);

    // asynchronous reset between edges in the middle of RUN
    step(4'b0001, 16'h0009);
    for (int k = 0; k < 20 && !(m_active && m_t == 5); k++)
      step(4'b0001, 16'h0009);
    check_outputs();
    #2 reset = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_enable", 32'(bus.cnt_enable), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    m_active   = 1'b0;
    m_ptr      = 0;
    bus.req    = '0;
    @(negedge clock);
    check("rst_hold_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    hold_until_done(4'b0100, 16'h0200);
    step('0, '0);

    // random traffic: requesters hold until done, occasionally abort
    rq = '0;
    ln = '0;
    repeat (800) begin
      for (int i = 0; i < NREQ; i++) begin
        own = m_active && (m_owner == i);
        if (own && m_t == m_len + 3)
          rq[i] = 1'b0;
        else if (own && m_t <= m_len + 2 && $urandom_range(0, 39) == 0)
          rq[i] = 1'b0;
        else if (!rq[i] && $urandom_range(0, 3) == 0)
          rq[i] = 1'b1;
        if (!rq[i] || own)
          ln[i*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? 4'hF : WIDTH'($urandom_range(0, 6));
      end
      step(rq, ln);
    end
    for (int k = 0; k < 30 && m_active; k++)
      step('0, ln);
    step('0, ln);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_arbiter.md
# counter_arbiter

Controller that shares one 4-bit up-counter (the lab's synchronous-reset, enable-gated counter) among several requesters, each asking to time an interval of a requested length. It selects one requester at a time, clears the counter, enables it until the requested count is reached, then signals completion. It sits between requesting logic and the counter: it drives the counter's reset and enable and reads its output back.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 4: counter width; must match the shared counter.
- clock  in  1  rising-edge clock shared with the counter.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req  in  NREQ  per-requester request level; held until the matching done or grant.
- len  in  NREQ*WIDTH  packed interval lengths; requester i uses len[i*WIDTH +: WIDTH]; sampled only at grant.
- grant  out  NREQ  one-hot owner of the counter; all zero when idle.
- done  out  NREQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.
- cnt_reset  out  1  to the counter's reset input (active-high, synchronous).
- cnt_enable  out  1  to the counter's enable input.
- cnt_value  in  WIDTH  counter's counter_out.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. All outputs are registered or decoded from registered state only.
- IDLE: if any req bit is high, choose a winner, latch its len into len_q, set grant one-hot, and go to CLEAR. Otherwise stay.
- CLEAR: cnt_reset=1 for exactly one cycle, then go to RUN.
- RUN: cnt_enable = (cnt_value != len_q). When cnt_value == len_q, go to DONE.
- DONE: done[winner]=1 for one cycle, then go to IDLE. grant clears on entry to IDLE.
- Abort: if req[winner] drops in CLEAR or RUN, go to IDLE next cycle. No done pulse is issued and the counter is left as-is.
- len_q = 0: CLEAR → RUN → DONE with no enable cycles.
- len changes after grant are ignored. A new req during CLEAR, RUN or DONE waits for IDLE.
- A requester whose req is still high on return to IDLE may be re-granted, subject to the arbitration policy.
- Reset (reset=0) at any time forces IDLE, with grant=0, done=0, busy=0, cnt_reset=0, cnt_enable=0, len_q=0, and the round-robin pointer at 0. It takes effect immediately and asynchronously. The external counter is not cleared by this block until the next CLEAR.

## Timing
- If req is seen in IDLE at cycle 0:
  - grant, busy and cnt_reset are high in cycle 1.
  - RUN starts in cycle 2 with cnt_value=0.
  - cnt_enable is high in cycles 2..L+1.
  - cnt_value==L in cycle L+2.
  - done pulses in cycle L+3.
  - The block is back in IDLE in cycle L+4.
- grant and busy stay high for cycles 1..L+3 inclusive.
- Back-to-back operation: a pending req is granted in the first IDLE cycle, so there is one idle cycle between operations.
- The counter's #1 output delay is tolerated. cnt_value is sampled at the rising edge only.

## Configuration
- COUNTER_ARB_RR_EN defined: round-robin arbitration.
  - The search starts at index ptr and wraps from NREQ-1 to 0.
  - On each grant, ptr ← winner+1 modulo NREQ.
- COUNTER_ARB_RR_EN undefined: fixed priority, lowest index wins; ptr logic is removed.

## Test plan
- Single request: reset, then req=0001 with len0=3 at cycle 0. Required: grant=0001 in cycles 1..6, cnt_reset in cycle 1, cnt_enable in cycles 2..4, cnt_value=3 in cycle 5, done=0001 in cycle 6, busy=0 in cycle 7.
- Zero length: req=0010 with len1=0. Required: no cnt_enable cycles, and done=0010 three cycles after the request is seen.
- Contention with COUNTER_ARB_RR_EN: req=1111 held, each len=1. Required: grant order 0,1,2,3,0.
- Contention without COUNTER_ARB_RR_EN: the same stimulus gives grant order 0,0,0.
- Abort: req0 dropped in RUN while cnt_value=2 and len0=9. Required: next cycle in IDLE, grant=0, no done, cnt_enable=0.
- Asynchronous reset: reset=0 mid-RUN between clock edges. Required: immediately grant=0, busy=0, cnt_enable=0. After release with req=0100, grant=0100 follows in the standard sequence.
